// File: rtl/vec_mul_ctrl.sv
// Sequencer for one systolic-array tile: weight load, vector feed, pipeline drain,
// result write-back and a completion pulse. All outputs are registered Moore decodes.
module vec_mul_ctrl #(
    parameter int ADDRESSSIZE  = 10,
    parameter int MATRIX_SIZE  = 8,
    parameter int DRAIN_CYCLES = 2 * MATRIX_SIZE - 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   fifo_empty,
    input  logic [ADDRESSSIZE-1:0] ub_base,
    input  logic [ADDRESSSIZE-1:0] res_base,
    output logic                   fifo_read_enable,
    output logic                   weight_load,
    output logic                   ub_read_en,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic                   busy,
    output logic                   end_,
    output logic [4:0]             state_count
);

    localparam int CW = 5;
    localparam logic [CW-1:0] FEED_LAST  = CW'(MATRIX_SIZE - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDRESSSIZE-1:0] ub_base_q, ub_base_d;
    logic [ADDRESSSIZE-1:0] res_base_q, res_base_d;

    logic                   fifo_re_q;
    logic                   weight_load_q;
    logic                   ub_en_q;
    logic [ADDRESSSIZE-1:0] ub_addr_q;
    logic                   res_we_q;
    logic [ADDRESSSIZE-1:0] res_addr_q;
    logic                   busy_q;
    logic                   end_q;

    // Next-state and counter: the counter restarts at zero on every state entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        ub_base_d  = ub_base_q;
        res_base_d = res_base_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !fifo_empty) begin
                    state_d    = S_LOAD_W;
                    ub_base_d  = ub_base;
                    res_base_d = res_base;
                end
            end
            S_LOAD_W: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end
            end
            S_WRITE: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so they line up with state_q.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ub_base_q     <= '0;
            res_base_q    <= '0;
            fifo_re_q     <= 1'b0;
            weight_load_q <= 1'b0;
            ub_en_q       <= 1'b0;
            ub_addr_q     <= '0;
            res_we_q      <= 1'b0;
            res_addr_q    <= '0;
            busy_q        <= 1'b0;
            end_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ub_base_q     <= ub_base_d;
            res_base_q    <= res_base_d;
            fifo_re_q     <= (state_d == S_LOAD_W);
            weight_load_q <= (state_d == S_LOAD_W);
            ub_en_q       <= (state_d == S_FEED);
            ub_addr_q     <= (state_d == S_FEED)
                             ? ub_base_d + ADDRESSSIZE'(cnt_d) : '0;
            res_we_q      <= (state_d == S_WRITE);
            res_addr_q    <= (state_d == S_WRITE)
                             ? res_base_d + ADDRESSSIZE'(cnt_d) : '0;
            busy_q        <= (state_d != S_IDLE);
            end_q         <= (state_d == S_DONE);
        end
    end

    assign fifo_read_enable = fifo_re_q;
    assign weight_load      = weight_load_q;
    assign ub_read_en       = ub_en_q;
    assign ub_address       = ub_addr_q;
    assign res_we           = res_we_q;
    assign res_address      = res_addr_q;
    assign busy             = busy_q;
    assign end_             = end_q;
    assign state_count      = cnt_q;

endmodule

// File: tb/tb_vec_mul_ctrl.sv
// Self-checking bench for vec_mul_ctrl: table-driven tiles plus hand-written corner
// sequences, with a scoreboard of expected strobes checked on the falling edge.
module tb_vec_mul_ctrl;

    localparam int A  = 10;
    localparam int MS = 8;
    localparam int DC = 2 * MS - 1;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         start = 1'b0;
    logic         fifo_empty = 1'b0;
    logic [A-1:0] ub_base = '0;
    logic [A-1:0] res_base = '0;
    logic         fifo_read_enable, weight_load, ub_read_en, res_we, busy, end_;
    logic [A-1:0] ub_address, res_address;
    logic [4:0]   state_count;

    vec_mul_ctrl #(.ADDRESSSIZE(A), .MATRIX_SIZE(MS), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rstn(rstn), .start(start), .fifo_empty(fifo_empty),
        .ub_base(ub_base), .res_base(res_base),
        .fifo_read_enable(fifo_read_enable), .weight_load(weight_load),
        .ub_read_en(ub_read_en), .ub_address(ub_address),
        .res_we(res_we), .res_address(res_address),
        .busy(busy), .end_(end_), .state_count(state_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [A-1:0] addr;
        int           idx;
        int           at;
    } exp_t;

    exp_t         ubq[$];
    exp_t         resq[$];
    int           endq[$];
    int           freq[$];
    int           win_s[$];
    int           win_e[$];
    exp_t         e_ub, e_res;
    logic [A-1:0] last_ub = '0;
    logic [A-1:0] last_res = '0;
    int           last_t0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy_exp(input int c);
        foreach (win_s[i])
            if (c >= win_s[i] && c <= win_e[i]) return 1'b1;
        return 1'b0;
    endfunction

    // t0 is the counter value during the LOAD_W cycle (cycle 1 after the accepting edge).
    task automatic push_tile(input int t0, input logic [A-1:0] ub, input logic [A-1:0] rb);
        exp_t e;
        for (int k = 0; k < MS; k++) begin
            e.addr = ub + A'(k);
            e.idx  = k;
            e.at   = t0 + 1 + k;
            ubq.push_back(e);
            e.addr = rb + A'(k);
            e.at   = t0 + 1 + MS + DC + k;
            resq.push_back(e);
        end
        freq.push_back(t0);
        endq.push_back(t0 + 1 + 2 * MS + DC);
        win_s.push_back(t0);
        win_e.push_back(t0 + 1 + 2 * MS + DC);
        last_t0 = t0;
    endtask

    always @(negedge clk) begin
        check("busy", busy, busy_exp(cyc));
        check("wl_vs_fre", weight_load, fifo_read_enable);
        if (!busy) check("idle_count", state_count, 0);
        if (ub_read_en) begin
            if (ubq.size() == 0) check("ub_unexpected", ub_read_en, 1'b0);
            else begin
                e_ub = ubq.pop_front();
                check("ub_address", ub_address, e_ub.addr);
                check("ub_cycle", cyc, e_ub.at);
                check("feed_count", state_count, e_ub.idx);
                last_ub = ub_address;
            end
        end else check("ub_addr_idle", ub_address, 0);
        if (res_we) begin
            if (resq.size() == 0) check("res_unexpected", res_we, 1'b0);
            else begin
                e_res = resq.pop_front();
                check("res_address", res_address, e_res.addr);
                check("res_cycle", cyc, e_res.at);
                check("write_count", state_count, e_res.idx);
                last_res = res_address;
            end
        end else check("res_addr_idle", res_address, 0);
        if (fifo_read_enable) begin
            if (freq.size() == 0) check("fre_unexpected", fifo_read_enable, 1'b0);
            else check("fre_cycle", cyc, freq.pop_front());
            check("load_count", state_count, 0);
        end
        if (end_) begin
            if (endq.size() == 0) check("end_unexpected", end_, 1'b0);
            else check("end_cycle", cyc, endq.pop_front());
            check("done_count", state_count, 0);
        end
    end

    task automatic start_tile(input logic [A-1:0] ub, input logic [A-1:0] rb);
        @(posedge clk);
        #2;
        start = 1'b1; fifo_empty = 1'b0; ub_base = ub; res_base = rb;
        @(posedge clk);
        #1 push_tile(cyc, ub, rb);
        #1;
        start = 1'b0;
        ub_base = A'($urandom);
        res_base = A'($urandom);
        fifo_empty = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 120 && endq.size() != 0; i++) @(posedge clk);
        check(name, endq.size(), 0);
        check({name, "_ubq"}, ubq.size(), 0);
        check({name, "_resq"}, resq.size(), 0);
        endq.delete(); ubq.delete(); resq.delete(); freq.delete();
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [A-1:0] ub;
        logic [A-1:0] rb;
        logic         fe;
        logic         accept;
        logic [A-1:0] ub_last;
        logic [A-1:0] res_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{ub: 10'h010, rb: 10'h000, fe: 1'b0, accept: 1'b1, ub_last: 10'h017, res_last: 10'h007};
        vecs[1] = '{ub: 10'h000, rb: 10'h000, fe: 1'b1, accept: 1'b0, ub_last: 10'h000, res_last: 10'h000};
        vecs[2] = '{ub: 10'h3FE, rb: 10'h123, fe: 1'b0, accept: 1'b1, ub_last: 10'h005, res_last: 10'h12A};
        vecs[3] = '{ub: 10'h155, rb: 10'h3FC, fe: 1'b0, accept: 1'b1, ub_last: 10'h15C, res_last: 10'h003};
        vecs[4] = '{ub: 10'h2A0, rb: 10'h3FF, fe: 1'b0, accept: 1'b1, ub_last: 10'h2A7, res_last: 10'h006};

        #2 rstn = 1'b0;
        #1 check("reset_outputs", {fifo_read_enable, weight_load, ub_read_en, ub_address,
                                   res_we, res_address, busy, end_, state_count}, 0);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].accept) begin
                start_tile(vecs[i].ub, vecs[i].rb);
                wait_done($sformatf("vec%0d_done", i));
                check($sformatf("vec%0d_ub_last", i), last_ub, vecs[i].ub_last);
                check($sformatf("vec%0d_res_last", i), last_res, vecs[i].res_last);
            end else begin
                @(posedge clk);
                #2;
                start = 1'b1; fifo_empty = vecs[i].fe;
                ub_base = vecs[i].ub; res_base = vecs[i].rb;
                repeat (40) @(posedge clk);
                #1;
                check($sformatf("vec%0d_empty_busy", i), busy, 0);
                check($sformatf("vec%0d_empty_count", i), state_count, 0);
                #1;
                start = 1'b0; fifo_empty = 1'b0;
            end
        end

        // start pulses during FEED and WRITE must be ignored
        start_tile(10'h200, 10'h300);
        wait_cyc(last_t0 + 3);
        start = 1'b1; fifo_empty = 1'b0;
        @(posedge clk);
        #2 start = 1'b0;
        wait_cyc(last_t0 + 26);
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("ignore_start_done");
        repeat (5) @(posedge clk);

        // asynchronous reset in DRAIN aborts the tile, then a fresh tile runs in full
        start_tile(10'h040, 10'h080);
        fifo_empty = 1'b0;
        wait_cyc(last_t0 + 14);
        #1;
        resq.delete(); endq.delete();
        win_e[win_e.size() - 1] = cyc - 1;
        rstn = 1'b0;
        #1 check("midtile_reset_outputs", {fifo_read_enable, weight_load, ub_read_en, ub_address,
                                           res_we, res_address, busy, end_, state_count}, 0);
        start = 1'b1; ub_base = 10'h100; res_base = 10'h200;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1 push_tile(cyc, 10'h100, 10'h200);
        #1 start = 1'b0;
        wait_done("after_reset_done");
        check("after_reset_res_last", last_res, 10'h207);

        // start held high: back-to-back tiles every 34 cycles
        @(posedge clk);
        #2;
        start = 1'b1; fifo_empty = 1'b0; ub_base = 10'h0F0; res_base = 10'h1F0;
        @(posedge clk);
        #1;
        begin
            int t0;
            t0 = cyc;
            for (int i = 0; i < 3; i++) push_tile(t0 + 34 * i, 10'h0F0, 10'h1F0);
            wait_cyc(t0 + 80);
        end
        start = 1'b0;
        wait_done("held_start_done");
        repeat (5) @(posedge clk);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end

endmodule
